// File: rtl/trace_char_arbiter.sv
// Round-robin arbiter: latches one null-terminated record from one requester and
// streams it a byte per cycle. Define TRACE_ARB_SEP_EN to append a '|' after each record.
module trace_char_arbiter #(
  parameter int unsigned p_nreqs  = 4,
  parameter int unsigned p_nchars = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             req_val,
  output logic [p_nreqs-1:0]             req_rdy,
  input  logic [p_nreqs*p_nchars*8-1:0]  req_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [7:0]                     out_msg,
  output logic [$clog2(p_nreqs)-1:0]     out_owner,
  output logic                           busy
);

  localparam int unsigned NB = p_nchars * 8;
  localparam int unsigned OW = $clog2(p_nreqs);
  localparam int unsigned CW = $clog2(p_nchars + 1);
  localparam logic [7:0]  SEP_CHAR = 8'h7C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
`ifdef TRACE_ARB_SEP_EN
    , S_SEP = 2'd2
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [NB-1:0]   r_buf;
  logic [CW-1:0]   r_cnt;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   r_owner;

  logic            w_found;
  logic [OW-1:0]   w_gidx;
  logic [OW-1:0]   w_i;
  logic [NB-1:0]   w_slice;
  logic [NB-1:0]   w_buf_shl;
  logic            w_first_nz;
  logic            w_last;
  logic            w_grant;
  logic            w_shift;

  // Rotating priority search starting at r_ptr
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_i     = r_ptr;
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      if (!w_found && req_val[w_i]) begin
        w_found = 1'b1;
        w_gidx  = w_i;
      end
      w_i = (w_i == OW'(p_nreqs - 1)) ? '0 : w_i + OW'(1);
    end
  end

  always_comb begin
    w_slice = '0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      if (w_gidx == OW'(i)) w_slice = req_msg[i*NB +: NB];
    end
  end

  assign w_first_nz = |w_slice[NB-1 -: 8];
  assign w_buf_shl  = r_buf << 8;
  // Last character when the counter reaches the end or the following byte terminates
  assign w_last     = (r_cnt == CW'(p_nchars - 1)) || (w_buf_shl[NB-1 -: 8] == 8'h00);
  assign out_owner  = r_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    req_rdy    = '0;
    out_val    = 1'b0;
    out_msg    = 8'h00;
    busy       = 1'b1;
    w_grant    = 1'b0;
    w_shift    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_found) begin
          req_rdy[w_gidx] = 1'b1;
          w_grant         = 1'b1;
          if (w_first_nz) w_state_nx = S_SEND;
`ifdef TRACE_ARB_SEP_EN
          else            w_state_nx = S_SEP;
`else
          else            w_state_nx = S_IDLE;
`endif
        end
      end
      S_SEND: begin
        out_val = 1'b1;
        out_msg = r_buf[NB-1 -: 8];
        if (out_rdy) begin
          w_shift = 1'b1;
`ifdef TRACE_ARB_SEP_EN
          if (w_last) w_state_nx = S_SEP;
`else
          if (w_last) w_state_nx = S_IDLE;
`endif
        end
      end
`ifdef TRACE_ARB_SEP_EN
      S_SEP: begin
        out_val = 1'b1;
        out_msg = SEP_CHAR;
        if (out_rdy) w_state_nx = S_IDLE;
      end
`endif
      default: begin
        busy       = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Record buffer, character count, grant owner and priority pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (w_grant) begin
      r_buf   <= w_slice;
      r_cnt   <= '0;
      r_owner <= w_gidx;
      r_ptr   <= (w_gidx == OW'(p_nreqs - 1)) ? '0 : w_gidx + OW'(1);
    end else if (w_shift) begin
      r_buf   <= w_buf_shl;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule
